// File: rtl/audio_in_deserializer_if.sv
// Host-side read bus of the I2S ADC deserializer.
// Carries the pop request and the show-ahead head-of-FIFO pair plus FIFO status.
//   read_en            : pop the head pair (host -> deserializer)
//   left_channel_data  : head-of-FIFO left sample
//   right_channel_data : head-of-FIFO right sample
//   fifo_count         : stereo pairs stored, 0..2^FIFO_AW
//   fifo_empty         : no pairs stored
//   fifo_full          : 2^FIFO_AW pairs stored
//   overflow           : sticky, a completed pair was dropped
// Modports: master = host side, slave = deserializer side.
interface audio_in_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_AW    = 4
);
    logic                  read_en;
    logic [DATA_WIDTH-1:0] left_channel_data;
    logic [DATA_WIDTH-1:0] right_channel_data;
    logic [FIFO_AW:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  overflow;

    modport master (
        output read_en,
        input  left_channel_data, right_channel_data, fifo_count,
        input  fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  read_en,
        output left_channel_data, right_channel_data, fifo_count,
        output fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/audio_in_deserializer.sv
// I2S ADC input deserializer: assembles left/right words from the serial stream
// and buffers complete stereo pairs (left then right) in a show-ahead FIFO.
// Ports:
//   clk, reset                  : system clock, synchronous active-high reset
//   clear_fifo                  : synchronous flush of FIFO, overflow and partial word
//   bit_clk_rising_edge         : one-cycle strobe, BCLK rose
//   left_right_clk_rising_edge  : one-cycle strobe, LRCK rose (right word begins)
//   left_right_clk_falling_edge : one-cycle strobe, LRCK fell (left word begins)
//   counting                    : bit-window enable from the bit counter
//   serial_data_in              : ADCDAT, already synchronised to clk
//   host                        : host read bus (slave modport)
module audio_in_deserializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input logic clk,
    input logic reset,
    input logic clear_fifo,
    input logic bit_clk_rising_edge,
    input logic left_right_clk_rising_edge,
    input logic left_right_clk_falling_edge,
    input logic counting,
    input logic serial_data_in,
    audio_in_deserializer_if.slave host
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = $clog2(DATA_WIDTH + 1);

    // Word assembly state
    logic                  word_active;
    logic                  word_right;    // channel of the word being assembled
    logic                  left_valid;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [CW-1:0]         bits_captured;

    // FIFO state
    logic [DATA_WIDTH-1:0] left_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] right_mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    logic                  overflow_q;

    logic                  lr_edge;
    logic                  bit_take;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [DATA_WIDTH-1:0] finished_word;
    logic [FIFO_AW:0]      count_next;

    always_comb begin
        lr_edge  = left_right_clk_rising_edge | left_right_clk_falling_edge;
        // Short words are left-aligned; with zero bits captured the shift is 0 anyway.
        finished_word = shift << (DATA_WIDTH - 32'(bits_captured));
        bit_take = bit_clk_rising_edge & counting & word_active & ~lr_edge &
                   (bits_captured < CW'(DATA_WIDTH));
        empty    = (count == '0);
        full     = (count == (FIFO_AW + 1)'(DEPTH));
        // A right word only completes a pair if a left word precedes it.
        push     = lr_edge & word_active & word_right & left_valid;
        pop      = host.read_en & ~empty;
        // A pop in the same cycle frees the slot for a push into a full FIFO.
        push_ok  = push & (~full | pop);
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_active   <= 1'b0;
            word_right    <= 1'b0;
            left_valid    <= 1'b0;
            shift         <= '0;
            left_hold     <= '0;
            bits_captured <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                left_mem[i]  <= '0;
                right_mem[i] <= '0;
            end
        end else if (clear_fifo) begin
            word_active   <= 1'b0;
            left_valid    <= 1'b0;
            shift         <= '0;
            bits_captured <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (lr_edge) begin
                if (word_active && !word_right) begin
                    left_hold  <= finished_word;
                    left_valid <= 1'b1;
                end else if (push) begin
                    left_valid <= 1'b0;
                end
                shift         <= '0;
                bits_captured <= '0;
                word_active   <= 1'b1;
                word_right    <= left_right_clk_rising_edge;
            end else if (bit_take) begin
                // MSB first; truncation to DATA_WIDTH keeps this valid for width 1.
                shift         <= DATA_WIDTH'({shift, serial_data_in});
                bits_captured <= bits_captured + 1'b1;
            end

            if (push_ok) begin
                left_mem[wr_ptr]  <= left_hold;
                right_mem[wr_ptr] <= finished_word;
                wr_ptr            <= wr_ptr + 1'b1;
            end else if (push) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Show-ahead: the head entry is read straight from storage. While empty the
    // slot under rd_ptr is not written, so the outputs hold steady.
    assign host.left_channel_data  = left_mem[rd_ptr];
    assign host.right_channel_data = right_mem[rd_ptr];
    assign host.fifo_count         = count;
    assign host.fifo_empty         = empty;
    assign host.fifo_full          = full;
    assign host.overflow           = overflow_q;
endmodule

// File: tb/tb_audio_in_deserializer.sv
// Testbench for audio_in_deserializer: directed scenarios followed by randomized
// frames, checked against a queue-based model of words, pairs and the FIFO.
module tb_audio_in_deserializer;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset, clear_fifo, bit_clk_rising_edge, left_right_clk_rising_edge;
    logic left_right_clk_falling_edge, counting, serial_data_in;

    audio_in_deserializer_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) host_bus ();

    audio_in_deserializer #(.DATA_WIDTH(DW), .FIFO_AW(AW)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .clear_fifo                  (clear_fifo),
        .bit_clk_rising_edge         (bit_clk_rising_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge),
        .counting                    (counting),
        .serial_data_in              (serial_data_in),
        .host                        (host_bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rnd   = 1'b0;

    // Reference model
    logic [31:0] mq[$];          // {left, right} pairs
    bit          bitq[$];        // bits captured for the open word, in arrival order
    bit          m_ovf, m_lvalid, m_open, m_open_right;
    logic [15:0] m_lhold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] word_value();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < bitq.size() && i < DW; i++) v[DW-1-i] = bitq[i];
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        bitq.delete();
        m_ovf = 0; m_lvalid = 0; m_open = 0; m_open_right = 0; m_lhold = '0;
    endtask

    task automatic check_head(input string tag);
        logic [31:0] p;
        p = mq[0];
        check({tag, "_left"}, 32'(host_bus.left_channel_data), {16'h0, p[31:16]});
        check({tag, "_right"}, 32'(host_bus.right_channel_data), {16'h0, p[15:0]});
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(host_bus.fifo_count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(host_bus.fifo_empty), 32'(mq.size() == 0));
        check({tag, "_full"}, 32'(host_bus.fifo_full), 32'(mq.size() == DEPTH));
        check({tag, "_ovf"}, 32'(host_bus.overflow), 32'(m_ovf));
        if (mq.size() > 0) check_head(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_clear();
        clear_fifo = 1'b1;
        tick();
        clear_fifo = 1'b0;
        mq.delete();
        bitq.delete();
        m_ovf = 0; m_lvalid = 0; m_open = 0;
    endtask

    // Send the n LSBs of val, MSB first, one BCLK strobe per bit.
    task automatic send_bits(input logic [31:0] val, input int n);
        int gap;
        for (int i = n - 1; i >= 0; i--) begin
            gap = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                serial_data_in = 1'($urandom);
                counting       = 1'($urandom);
                tick();
            end
            serial_data_in      = val[i];
            counting            = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            bit_clk_rising_edge = 1'b1;
            tick();
            if (counting && m_open) bitq.push_back(serial_data_in);
            bit_clk_rising_edge = 1'b0;
            counting            = 1'b0;
        end
    endtask

    task automatic lr_edge(input bit rising, input bit rd);
        logic [15:0] w;
        logic [31:0] pr;
        logic [31:0] dummy;
        bit          push, do_pop, was_full;
        w    = word_value();
        push = 0;
        pr   = '0;
        if (m_open) begin
            if (!m_open_right) begin
                m_lhold  = w;
                m_lvalid = 1;
            end else if (m_lvalid) begin
                push     = 1;
                pr       = {m_lhold, w};
                m_lvalid = 0;
            end
        end
        m_open       = 1;
        m_open_right = rising;
        bitq.delete();
        if (rd && mq.size() > 0) check_head("edge_pop");
        left_right_clk_rising_edge  = rising;
        left_right_clk_falling_edge = !rising;
        host_bus.read_en            = rd;
        tick();
        left_right_clk_rising_edge  = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        host_bus.read_en            = 1'b0;
        was_full = (mq.size() == DEPTH);
        do_pop   = rd && (mq.size() > 0);
        if (do_pop) dummy = mq.pop_front();
        if (push) begin
            if (was_full && !do_pop) m_ovf = 1;
            else mq.push_back(pr);
        end
    endtask

    task automatic pop();
        logic [31:0] dummy;
        if (mq.size() > 0) check_head("pop");
        host_bus.read_en = 1'b1;
        tick();
        host_bus.read_en = 1'b0;
        if (mq.size() > 0) dummy = mq.pop_front();
    endtask

    // Assumes a left word was just opened by a falling edge.
    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r,
                              input int nr, input bit rd);
        send_bits(l, nl);
        lr_edge(1'b1, 1'b0);
        send_bits(r, nr);
        lr_edge(1'b0, rd);
    endtask

    logic [15:0] vals_l[5];
    logic [15:0] vals_r[5];

    initial begin
        reset = 1'b1; clear_fifo = 0; bit_clk_rising_edge = 0;
        left_right_clk_rising_edge = 0; left_right_clk_falling_edge = 0;
        counting = 0; serial_data_in = 0; host_bus.read_en = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_count", 32'(host_bus.fifo_count), 0);
        check("rst_empty", 32'(host_bus.fifo_empty), 1);
        check("rst_full", 32'(host_bus.fifo_full), 0);
        check("rst_ovf", 32'(host_bus.overflow), 0);
        check("rst_left", 32'(host_bus.left_channel_data), 0);
        check("rst_right", 32'(host_bus.right_channel_data), 0);

        // One full frame
        lr_edge(1'b0, 1'b0);
        send_frame(32'hA5C3, 16, 32'h1234, 16, 1'b0);
        check("frame_count", 32'(host_bus.fifo_count), 1);
        check("frame_left", 32'(host_bus.left_channel_data), 32'hA5C3);
        check("frame_right", 32'(host_bus.right_channel_data), 32'h1234);
        check("frame_ovf", 32'(host_bus.overflow), 0);
        check_state("frame");

        // Start-up alignment: right word first is discarded
        do_reset();
        lr_edge(1'b1, 1'b0);
        send_bits(32'h5555, 16);
        lr_edge(1'b0, 1'b0);
        check("align_discard", 32'(host_bus.fifo_count), 0);
        send_frame(32'h0F0F, 16, 32'hBEEF, 16, 1'b0);
        check("align_left", 32'(host_bus.left_channel_data), 32'h0F0F);
        check("align_right", 32'(host_bus.right_channel_data), 32'hBEEF);
        check_state("align");
        pop();
        check_state("align_pop");

        // Long and short words
        send_frame(32'hABCDEF, 24, 32'hFFF, 12, 1'b0);
        check("long_word", 32'(host_bus.left_channel_data), 32'hABCD);
        check("short_word", 32'(host_bus.right_channel_data), 32'hFFF0);
        check_state("lenmix");
        pop();

        // Overflow: 5 pairs, no reads
        for (int i = 0; i < 5; i++) begin
            vals_l[i] = 16'($urandom);
            vals_r[i] = 16'($urandom);
            send_frame(32'(vals_l[i]), 16, 32'(vals_r[i]), 16, 1'b0);
        end
        check("ovf_full", 32'(host_bus.fifo_full), 1);
        check("ovf_count", 32'(host_bus.fifo_count), 4);
        check("ovf_flag", 32'(host_bus.overflow), 1);
        check_state("ovf");
        for (int i = 0; i < 4; i++) begin
            check("ovf_rd_left", 32'(host_bus.left_channel_data), 32'(vals_l[i]));
            check("ovf_rd_right", 32'(host_bus.right_channel_data), 32'(vals_r[i]));
            pop();
        end
        check_state("ovf_drained");

        // Flush mid-word
        send_bits(32'hA5, 8);
        do_clear();
        check("clr_empty", 32'(host_bus.fifo_empty), 1);
        check("clr_ovf", 32'(host_bus.overflow), 0);
        send_bits(32'h3C, 8);
        lr_edge(1'b1, 1'b0);
        send_bits(32'h7777, 16);
        lr_edge(1'b0, 1'b0);
        check("clr_discard", 32'(host_bus.fifo_count), 0);
        send_frame(32'h1111, 16, 32'h2222, 16, 1'b0);
        check("clr_left", 32'(host_bus.left_channel_data), 32'h1111);
        check("clr_right", 32'(host_bus.right_channel_data), 32'h2222);
        check_state("clr");
        pop();

        // Simultaneous push/pop when full
        for (int i = 0; i < 4; i++) send_frame(32'($urandom), 16, 32'($urandom), 16, 1'b0);
        check_state("full4");
        send_frame(32'hC0DE, 16, 32'hF00D, 16, 1'b1);
        check("pp_count", 32'(host_bus.fifo_count), 4);
        check("pp_ovf", 32'(host_bus.overflow), 0);
        check_state("pp");
        for (int i = 0; i < 4; i++) pop();
        check_state("pp_drained");

        // Reset mid-word
        send_frame(32'h4242, 16, 32'h2424, 16, 1'b0);
        send_bits(32'h99, 8);
        do_reset();
        check("mrst_count", 32'(host_bus.fifo_count), 0);
        check("mrst_empty", 32'(host_bus.fifo_empty), 1);
        check("mrst_full", 32'(host_bus.fifo_full), 0);
        check("mrst_ovf", 32'(host_bus.overflow), 0);
        check("mrst_left", 32'(host_bus.left_channel_data), 0);
        check("mrst_right", 32'(host_bus.right_channel_data), 0);
        send_bits(32'h66, 8);
        lr_edge(1'b1, 1'b0);
        send_bits(32'h8888, 16);
        lr_edge(1'b0, 1'b0);
        check("mrst_discard", 32'(host_bus.fifo_count), 0);
        send_frame(32'h1357, 16, 32'h2468, 16, 1'b0);
        check_state("mrst");

        // Randomized frames
        rnd = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int nl, nr;
            nl = ($urandom_range(0, 1) != 0) ? 16 : int'($urandom_range(1, 24));
            nr = ($urandom_range(0, 1) != 0) ? 16 : int'($urandom_range(1, 24));
            send_frame(32'($urandom), nl, 32'($urandom), nr, $urandom_range(0, 3) == 0);
            check_state("rnd");
            if ($urandom_range(0, 2) == 0) pop();
            if ($urandom_range(0, 2) == 0) pop();
            if (it % 27 == 26) begin
                do_clear();
                check_state("rnd_clr");
                lr_edge(1'b1, 1'b0);
                send_bits(32'($urandom), 16);
                lr_edge(1'b0, 1'b0);
            end
        end
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
